// File: rtl/bch_encode_serial.sv
// Bit-serial systematic BCH encoder: message bits pass through, then the
// remainder of m(x)*x^(N-K) mod g(x) is shifted out, all from registered outputs.
module bch_encode_serial #(
  parameter int N = 15,
  parameter int K = 5,
  parameter logic [N-K:0] GEN = 11'h537
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic start,
  input  logic data_in,
  output logic data_ready,
  output logic data_out,
  output logic out_valid,
  output logic out_first,
  output logic out_last
);

  localparam int P = N - K;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] K_POS = CW'(K);
  localparam logic [CW-1:0] LAST_POS = CW'(N - 1);
  localparam logic [P-1:0] G_LO = GEN[P-1:0];

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic [P-1:0]    lfsr, nxt_lfsr;
  logic            nxt_bit, nxt_valid, nxt_first, nxt_last;

  // One step of division by g(x); the feedback folds the incoming bit in at the top.
  function automatic logic [P-1:0] div_step(input logic [P-1:0] r, input logic b);
    logic fb;
    fb = b ^ r[P-1];
    return (r << 1) ^ (fb ? G_LO : '0);
  endfunction

  assign data_ready = (state != PARITY);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_lfsr  = lfsr;
    nxt_bit   = data_out;
    nxt_valid = 1'b0;
    nxt_first = 1'b0;
    nxt_last  = 1'b0;
    if (ce) begin
      if (start) begin
        // A start restarts from a cleared remainder, whatever was in flight.
        nxt_lfsr  = div_step('0, data_in);
        nxt_bit   = data_in;
        nxt_valid = 1'b1;
        nxt_first = 1'b1;
        nxt_cnt   = CW'(1);
        nxt_state = (K == 1) ? PARITY : DATA;
      end else begin
        case (state)
          DATA: begin
            nxt_lfsr  = div_step(lfsr, data_in);
            nxt_bit   = data_in;
            nxt_valid = 1'b1;
            nxt_cnt   = cnt + CW'(1);
            if (cnt + CW'(1) == K_POS) nxt_state = PARITY;
          end
          PARITY: begin
            nxt_bit   = lfsr[P-1];
            nxt_valid = 1'b1;
            if (cnt == LAST_POS) begin
              nxt_last  = 1'b1;
              nxt_state = IDLE;
              nxt_cnt   = '0;
              nxt_lfsr  = '0;
            end else begin
              nxt_lfsr = lfsr << 1;
              nxt_cnt  = cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output stage: one register between the division step and the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr      <= '0;
      data_out  <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      lfsr      <= nxt_lfsr;
      data_out  <= nxt_bit;
      out_valid <= nxt_valid;
      out_first <= nxt_first;
      out_last  <= nxt_last;
    end
  end

endmodule

// File: tb/tb_bch_encode_serial.sv
// Directed + random bench for bch_encode_serial; a queue of expected codeword
// bits is filled as messages are driven and drained as the encoder emits them.
module tb_bch_encode_serial;

  localparam int N = 15;
  localparam int K = 5;
  localparam int P = N - K;
  localparam logic [N-K:0] GEN = 11'h537;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic start = 1'b0;
  logic data_in = 1'b0;
  logic data_ready, data_out, out_valid, out_first, out_last;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pos = 0;
  logic prev_out = 1'b0;
  logic [N-1:0] obs_word = '0;
  logic [N-1:0] last_cw = '0;

  bch_encode_serial #(.N(N), .K(K), .GEN(GEN)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .data_in(data_in),
    .data_ready(data_ready), .data_out(data_out), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P-1:0] mod_g(input logic [N-1:0] x);
    logic [N-1:0] v;
    v = x;
    for (int i = N - 1; i >= P; i--)
      if (v[i]) v = v ^ (N'(GEN) << (i - P));
    return v[P-1:0];
  endfunction

  function automatic logic [N-1:0] encode(input logic [K-1:0] msg);
    logic [N-1:0] v;
    v = {msg, {P{1'b0}}};
    return v | N'(mod_g(v));
  endfunction

  task automatic drive(input logic c, input logic s, input logic d);
    @(posedge clk);
    #1;
    chk("data_ready", 32'(data_ready), 32'(pos < K));
    ce = c;
    start = s;
    data_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [K-1:0] msg, input int stop_at, input int gap_pct,
                      input int hold_at);
    logic [N-1:0] cw;
    cw = encode(msg);
    if (pos != 0) repeat (N - pos) void'(sb.pop_back());
    for (int i = N - 1; i >= 0; i--)
      sb.push_back('{b: cw[i], first: (i == N - 1), last: (i == 0)});
    for (int j = 0; j < stop_at; j++) begin
      if (j == hold_at)
        repeat (10) drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      while (int'($urandom_range(99)) < gap_pct)
        drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      drive(1'b1, j == 0, (j < K) ? msg[K-1-j] : 1'($urandom_range(1)));
      pos = (j + 1 == N) ? 0 : j + 1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_first"}, 32'(out_first), 32'(0));
    chk({tag, "_out_last"}, 32'(out_last), 32'(0));
    chk({tag, "_data_ready"}, 32'(data_ready), 32'(1));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_out = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("extra_output", 32'(out_valid), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e.b));
          chk("out_first", 32'(out_first), 32'(e.first));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
        obs_word = {obs_word[N-2:0], data_out};
        if (out_last) begin
          last_cw = obs_word;
          chk("divisible_by_g", 32'(mod_g(obs_word)), 32'(0));
        end
      end else begin
        chk("data_out_hold", 32'(data_out), 32'(prev_out));
        chk("first_idle", 32'(out_first), 32'(0));
        chk("last_idle", 32'(out_last), 32'(0));
      end
      prev_out = data_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [K-1:0] m;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    send(5'b10000, N, 0, -1);
    idle(2);
    chk("cw_10000", 32'(last_cw), 32'h429B);

    send(5'b00001, N, 0, -1);
    idle(2);
    chk("cw_00001", 32'(last_cw), 32'h0537);

    send(5'b00000, N, 0, -1);
    idle(2);
    chk("cw_zero", 32'(last_cw), 32'h0000);

    // Restart in the middle of the message, then in the middle of the parity.
    send(5'b10110, 3, 0, -1);
    send(5'b01101, N, 0, -1);
    idle(2);
    chk("abort_data", 32'(last_cw), 32'(encode(5'b01101)));
    send(5'b11001, K + 7, 0, -1);
    send(5'b00111, N, 0, -1);
    idle(2);
    chk("abort_parity", 32'(last_cw), 32'(encode(5'b00111)));

    send(5'b10011, N, 0, 2);
    idle(2);
    chk("hold_data", 32'(last_cw), 32'(encode(5'b10011)));
    send(5'b01010, N, 0, K + 3);
    idle(2);
    chk("hold_parity", 32'(last_cw), 32'(encode(5'b01010)));

    // Asynchronous reset between edges while parity is being shifted out.
    send(5'b11111, 12, 0, -1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid_parity");
    sb.delete();
    pos = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    send(5'b10101, N, 0, -1);
    idle(2);
    chk("after_reset", 32'(last_cw), 32'(encode(5'b10101)));

    for (int i = 0; i < 200; i++) begin
      m = K'($urandom);
      send(m, N, 50, -1);
    end
    idle(3);
    chk("random_last", 32'(last_cw), 32'(encode(m)));
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch_encode_serial.md
# bch_encode_serial

Bit-serial systematic BCH encoder: the transmit-side counterpart of the serial syndrome calculators. Accepts K message bits one per enabled cycle, highest-degree coefficient first. Emits the N-bit codeword (message bits unchanged, then N−K parity bits) from a registered output. Parity comes from a division-by-generator LFSR. Sits between the data source and the channel/serializer.

## Interface
- N, 15, codeword length in bits
- K, 5, message length in bits (K < N)
- GEN, 11'h537, generator polynomial, N−K+1 bits, bit i = coefficient of x^i; GEN[N−K] must be 1 (default: BCH(15,5), t=3, g(x)=x^10+x^8+x^5+x^4+x^2+x+1)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ce  input  1  advance one bit position this cycle
- start  input  1  qualified by ce: data_in is message bit 0 of a new codeword
- data_in  input  1  message bit, sampled when ce && data_ready
- data_ready  output  1  encoder consumes data_in on the next ce
- data_out  output  1  registered codeword bit
- out_valid  output  1  data_out holds a new bit this cycle
- out_first  output  1  with out_valid: codeword bit 0 (first message bit)
- out_last  output  1  with out_valid: codeword bit N−1 (last parity bit)

## Operation
- P = N−K parity width. Position counter cnt, width clog2(N). LFSR lfsr[P−1:0].
- States:
  - IDLE: no codeword in progress.
  - DATA: message bits being accepted.
  - PARITY: parity bits being shifted out.
- IDLE: data_ready=1. ce && start loads the first bit and goes to DATA, or to PARITY if K=1. ce without start is ignored; no output.
- Message bit step (ce in DATA, or ce && start anywhere):
  - fb = data_in ^ lfsr[P−1]
  - lfsr ← (lfsr<<1) ^ (fb ? GEN[P−1:0] : 0); on start, use lfsr=0 as the old value.
  - Emit data_in.
  - cnt ← cnt+1, or 1 on start.
  - cnt reaching K → PARITY.
- PARITY, on ce:
  - data_ready=0; data_in is ignored.
  - Emit lfsr[P−1]; lfsr ← lfsr<<1.
  - cnt ← cnt+1.
  - After the N−1 position is emitted → IDLE, with lfsr=0 and cnt=0.
- ce && start in DATA or PARITY aborts the current codeword immediately and restarts per the start rule. The partial codeword is never completed; no out_last for it.
- start without ce has no effect.
- ce low: all state frozen; out_valid drops.

## Timing
- Reset (async assert, sync deassert by the source): IDLE, cnt=0, lfsr=0, data_out=0, out_valid=0, out_first=0, out_last=0, data_ready=1.
- data_ready is combinational from state only: 1 in IDLE and DATA, 0 in PARITY.
- Output latency: exactly one cycle. Bit consumed/generated on edge e appears on data_out/out_valid after edge e, for one cycle.
- Throughput: one codeword bit per ce; N ce cycles per codeword.
- Back-to-back codewords: start on the ce immediately after the one that emitted out_last. There is no idle gap; out_first follows out_last on consecutive cycles.
- out_first=1 only with the output of a start bit. out_last=1 only with position N−1.
- Gapped ce: outputs are produced only on ce cycles. Between those cycles out_valid=0, and data_out holds its last value.

## Test plan
- Reset mid-PARITY (rst_n low asynchronously between edges) → all outputs at reset values before the next edge. A following start produces a correct codeword.
- Message 1,0,0,0,0 with ce held high → data_out over 15 cycles = 100001010011011 (0x429B); out_first on cycle 1, out_last on cycle 15, data_ready low for cycles 6–15 after start.
- Message 0,0,0,0,1 → codeword 0x0537, equal to g(x). All-zero message → 15 zero bits.
- Random ce (~50% duty) with 200 random messages back-to-back → each codeword equals the software polynomial-division model. Each codeword is divisible by g(x); syndromes S1..S2t are all zero.
- start asserted at message bit 3 and at parity bit 7 → old codeword abandoned without out_last. New codeword correct; out_first marks the restart bit.
- ce low for 10 cycles mid-DATA and mid-PARITY → no out_valid and no state change; the resumed codeword matches the model.
